// File: rtl/gt_prbs_pkg.sv
// Shared types and constants for the GT PRBS31 loopback checker.
// Holds the per-lane lock FSM encoding, the 64b/66b data sync header and
// the PRBS31 (x^31 + x^28 + 1) generator taps and seed.
package gt_prbs_pkg;

  typedef enum logic {
    ST_SEEK   = 1'b0,
    ST_LOCKED = 1'b1
  } lane_state_e;

  // 64b/66b sync header marking a data block.
  localparam logic [1:0] SYNC_DATA = 2'b01;

  // Polynomial exponents of x^31 + x^28 + 1; register bit index is exponent-1.
  localparam int PRBS31_TAP_A = 31;
  localparam int PRBS31_TAP_B = 28;

  localparam logic [30:0] PRBS31_SEED = 31'h7FFF_FFFF;

  // Each lane starts from a distinct state so lanes are never identical.
  function automatic logic [30:0] lane_seed(input int lane);
    return PRBS31_SEED - 31'(lane);
  endfunction

endpackage

// File: rtl/gt_prbs_loopback_checker_if.sv
// Signal bundle for one gt_prbs_loopback_checker instance.
// master: the checker side (drives TX words and status).
// slave:  the gearbox / transceiver side (accepts TX, returns RX).
interface gt_prbs_loopback_checker_if #(
  parameter int P_LANES = 2,
  parameter int P_CNT_W = 32
);

  logic                         enable;
  logic                         clear;
  logic [P_LANES*64-1:0]        tx_data;
  logic [P_LANES*2-1:0]         tx_header;
  logic [P_LANES-1:0]           tx_valid;
  logic [P_LANES-1:0]           tx_ready;
  logic [P_LANES*64-1:0]        rx_data;
  logic [P_LANES*2-1:0]         rx_header;
  logic [P_LANES-1:0]           rx_valid;
  logic [P_LANES-1:0]           lane_lock;
  logic                         all_lock;
  logic [P_LANES*P_CNT_W-1:0]   err_cnt;

  modport master (
    input  enable, clear, tx_ready, rx_data, rx_header, rx_valid,
    output tx_data, tx_header, tx_valid, lane_lock, all_lock, err_cnt
  );

  modport slave (
    output enable, clear, tx_ready, rx_data, rx_header, rx_valid,
    input  tx_data, tx_header, tx_valid, lane_lock, all_lock, err_cnt
  );

endinterface

// File: rtl/prbs31_adv64.sv
// Combinational 64-step advance of a PRBS31 Fibonacci LFSR.
// state[30] is the oldest sequence bit, state[0] the newest. data[63] is the
// first new sequence bit (MSB first); data[30:0] is the state for the next word.
module prbs31_adv64
  import gt_prbs_pkg::*;
(
  input  logic [30:0] state,
  output logic [63:0] data
);

  // Unroll 64 LFSR steps; every step's feedback bit is also an output bit.
  always_comb begin
    logic [30:0] s;
    logic        nb;
    // NOTE: every combinational output gets a default before any branch or loop, so no path can hold a stale value and infer a latch.
    data = '0;
    s    = state;
    for (int i = 63; i >= 0; i--) begin
      nb      = s[PRBS31_TAP_A-1] ^ s[PRBS31_TAP_B-1];
      data[i] = nb;
      s       = {s[29:0], nb};
    end
  end

endmodule

// File: rtl/gt_prbs_loopback_checker.sv
// Multi-lane PRBS31 generator and self-synchronising loopback checker.
// TX: one PRBS31 generator per lane, advancing only on valid && ready.
// RX: per lane, the next word is predicted from the last 31 bits of the
// previous valid word; a SEEK/LOCKED FSM qualifies lock and counts errors.
// Optional feature: define GT_PRBS_ERR_INJECT_EN to add i_inject_err, which
// inverts bit 0 of the next accepted TX word on the selected lane.
module gt_prbs_loopback_checker
  import gt_prbs_pkg::*;
#(
  parameter int P_LANES      = 2,
  parameter int P_LOCK_CNT   = 16,
  parameter int P_UNLOCK_CNT = 4,
  parameter int P_CNT_W      = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic                       i_clear,
  output logic [P_LANES*64-1:0]      o_tx_data,
  output logic [P_LANES*2-1:0]       o_tx_header,
  output logic [P_LANES-1:0]         o_tx_valid,
  input  logic [P_LANES-1:0]         i_tx_ready,
  input  logic [P_LANES*64-1:0]      i_rx_data,
  input  logic [P_LANES*2-1:0]       i_rx_header,
  input  logic [P_LANES-1:0]         i_rx_valid,
  output logic [P_LANES-1:0]         o_lane_lock,
  output logic                       o_all_lock,
  output logic [P_LANES*P_CNT_W-1:0] o_err_cnt
`ifdef GT_PRBS_ERR_INJECT_EN
  ,
  input  logic [P_LANES-1:0]         i_inject_err
`endif
);

  localparam int GOOD_W = $clog2(P_LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(P_UNLOCK_CNT + 1);

  // Every lane always carries data blocks.
  assign o_tx_header = {P_LANES{SYNC_DATA}};

  // TX valid follows i_enable by one cycle on every lane.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: registers use non-blocking assignments so all flops sample pre-edge values regardless of statement order.
    if (i_rst) o_tx_valid <= '0;
    else       o_tx_valid <= {P_LANES{i_enable}};
  end

  // Aggregate lock is registered, trailing the lane locks by one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_all_lock <= 1'b0;
    else       o_all_lock <= &o_lane_lock;
  end

  for (genvar l = 0; l < P_LANES; l++) begin : g_lane
    localparam logic [30:0] SEED = lane_seed(l);

    // ---------------------------------------------------------------- TX
    logic [30:0] tx_state_q;
    logic [63:0] tx_word;
    logic        tx_accept;

    prbs31_adv64 u_tx_adv (
      .state (tx_state_q),
      .data  (tx_word)
    );

    assign tx_accept = o_tx_valid[l] & i_tx_ready[l];

    // Generator steps only when the gearbox takes the word, so the payload holds while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)          tx_state_q <= SEED;
      else if (tx_accept) tx_state_q <= tx_word[30:0];
    end

`ifdef GT_PRBS_ERR_INJECT_EN
    logic inject_pend_q;

    // An inject request waits for the next accepted word; the generator state itself is never touched.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                inject_pend_q <= 1'b0;
      else if (i_inject_err[l]) inject_pend_q <= 1'b1;
      else if (tx_accept)       inject_pend_q <= 1'b0;
    end

    assign o_tx_data[64*l +: 64] = tx_word ^ {63'd0, inject_pend_q};
`else
    assign o_tx_data[64*l +: 64] = tx_word;
`endif

    // ---------------------------------------------------------------- RX
    logic [63:0]        rx_word;
    logic [1:0]         rx_hdr;
    logic [63:0]        rx_expect;
    logic               rx_good;
    logic [30:0]        pred_q, pred_d;
    lane_state_e        state_q, state_d;
    logic [GOOD_W-1:0]  good_q, good_d;
    logic [BAD_W-1:0]   bad_q, bad_d;
    logic [P_CNT_W-1:0] err_q, err_d;

    assign rx_word = i_rx_data[64*l +: 64];
    assign rx_hdr  = i_rx_header[2*l +: 2];

    prbs31_adv64 u_rx_adv (
      .state (pred_q),
      .data  (rx_expect)
    );

    assign rx_good = (rx_word == rx_expect) && (rx_hdr == SYNC_DATA);

    // Lane FSM, run-length counters, error counter and predictor history.
    // The predictor starts at the lane seed so a directly looped-back lane
    // qualifies from its very first word.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q <= ST_SEEK;
        good_q  <= '0;
        bad_q   <= '0;
        err_q   <= '0;
        pred_q  <= SEED;
      end else begin
        state_q <= state_d;
        good_q  <= good_d;
        bad_q   <= bad_d;
        err_q   <= err_d;
        pred_q  <= pred_d;
      end
    end

    // Classify each valid RX word and apply the SEEK/LOCKED rules; clear wins over a same-cycle error.
    always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      err_d   = err_q;
      pred_d  = pred_q;

      if (i_rx_valid[l]) begin
        // Bad words still resynchronise the predictor.
        pred_d = rx_word[30:0];
        case (state_q)
          ST_SEEK: begin
            if (rx_good) begin
              if (good_q == GOOD_W'(P_LOCK_CNT - 1)) begin
                state_d = ST_LOCKED;
                good_d  = '0;
                bad_d   = '0;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else begin
              good_d = '0;
            end
          end
          ST_LOCKED: begin
            if (rx_good) begin
              bad_d = '0;
            end else begin
              if (err_q != '1) err_d = err_q + 1'b1;
              if (bad_q == BAD_W'(P_UNLOCK_CNT - 1)) begin
                state_d = ST_SEEK;
                bad_d   = '0;
                good_d  = '0;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end
          end
          default: state_d = ST_SEEK;
        endcase
      end

      if (i_clear) err_d = '0;
    end

    assign o_lane_lock[l]                    = (state_q == ST_LOCKED);
    assign o_err_cnt[P_CNT_W*l +: P_CNT_W]   = err_q;
  end

endmodule

// File: doc/gt_prbs_loopback_checker.md
GT_PRBS_LOOPBACK_CHECKER -- requirements
Module: gt_prbs_loopback_checker

Interface
REQ-001 SHALL have parameter P_LANES, default 2, number of independent GT lanes.
REQ-002 SHALL have parameter P_LOCK_CNT, default 16, consecutive good RX words required to lock.
REQ-003 SHALL have parameter P_UNLOCK_CNT, default 4, consecutive bad RX words that drop lock.
REQ-004 SHALL have parameter P_CNT_W, default 32, error-counter width per lane.
REQ-005 SHALL have ports, in order:
- i_clk, in, 1: single clock for all logic.
- i_rst, in, 1: asynchronous, active-high reset.
- i_enable, in, 1: enables TX generation.
- i_clear, in, 1: synchronous clear of all error counters.
- o_tx_data, out, P_LANES*64: per-lane PRBS payload, lane n at [64n+63:64n].
- o_tx_header, out, P_LANES*2: per-lane sync header.
- o_tx_valid, out, P_LANES: TX word valid.
- i_tx_ready, in, P_LANES: gearbox accepts the word.
- i_rx_data, in, P_LANES*64: received payload.
- i_rx_header, in, P_LANES*2: received sync header.
- i_rx_valid, in, P_LANES: RX word valid.
- o_lane_lock, out, P_LANES: per-lane checker locked.
- o_all_lock, out, 1: AND of o_lane_lock.
- o_err_cnt, out, P_LANES*P_CNT_W: per-lane saturating word-error count.

Function
REQ-006 SHALL generate per lane PRBS31 (x^31+x^28+1), 64 sequence bits per word, MSB first; seed 31'h7FFF_FFFF minus lane index.
REQ-007 SHALL drive o_tx_header 2'b01 on every lane at all times after reset.
REQ-008 SHALL set o_tx_valid[n] one cycle after i_enable rises and clear it one cycle after i_enable falls.
REQ-009 SHALL advance lane n generator only on o_tx_valid[n] && i_tx_ready[n]; while not ready, o_tx_data SHALL hold stable.
REQ-010 SHALL run the checker per lane as a self-synchronising predictor: expected word = PRBS31 advance of the previous valid RX word's last 31 bits.
REQ-011 SHALL classify each valid RX word as good when data equals expected and header is 2'b01; otherwise bad.
REQ-012 SHALL update the predictor from every valid RX word regardless of good or bad; it SHALL ignore words with i_rx_valid low.
REQ-013 SHALL implement per-lane FSM states SEEK and LOCKED; reset state is SEEK.
REQ-014 SEEK: good word increments good_cnt; bad word zeroes it; the P_LOCK_CNT-th consecutive good word moves the lane to LOCKED; o_lane_lock SHALL rise on the next cycle.
REQ-015 LOCKED: bad word increments o_err_cnt and bad_cnt; good word zeroes bad_cnt; the P_UNLOCK_CNT-th consecutive bad word moves the lane to SEEK and clears good_cnt.
REQ-016 SHALL increment o_err_cnt only in LOCKED; the counter SHALL saturate at all-ones.
REQ-017 i_clear SHALL zero all o_err_cnt the next cycle; if a bad word coincides with i_clear, the count SHALL become 0, not 1.
REQ-018 SHALL register o_all_lock one cycle after o_lane_lock.

Reset
REQ-019 On i_rst: o_tx_data SHALL take the seed-derived first word, o_tx_header 2'b01, o_tx_valid 0, o_lane_lock 0, o_all_lock 0, o_err_cnt 0; FSM SHALL be SEEK and good_cnt/bad_cnt 0.
REQ-020 Reset asserted mid-operation SHALL take effect immediately and restart generation from the seed.

Configuration
REQ-021 With macro GT_PRBS_ERR_INJECT_EN defined, SHALL add input i_inject_err (P_LANES); a pulse inverts bit 0 of the next accepted TX word on that lane only, and the generator state stays uncorrupted.
REQ-022 Without GT_PRBS_ERR_INJECT_EN, the port SHALL be absent and TX data SHALL always be pure PRBS.

Structure
REQ-023 Package gt_prbs_pkg SHALL hold the FSM state enum, the SYNC_DATA 2'b01 constant, and PRBS31 tap constants.
REQ-024 Sub-module prbs31_adv64 SHALL be a combinational 64-bit PRBS31 advance, instantiated once per lane for TX and once per lane for RX.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Loopback TX to RX, P_LANES=2, ready=1: both locks rise after 16 RX words; o_all_lock one cycle later; err_cnt stays 0 for 10000 words.
- In locked loopback, inject one flipped RX bit on lane 1: lane1 err_cnt=2 (the corrupted word and its successor's prediction); lock held; lane0 err_cnt=0.
- RX header forced to 2'b10 for 4 consecutive words on lane 0 while locked: err_cnt=4, lock drops on the following cycle; relock after 16 good words.
- i_tx_ready toggles 1,0,0,1: o_tx_data is constant through the low cycles; RX with valid mirroring handshake stays locked.
- i_clear asserted together with a bad word: err_cnt reads 0 the next cycle.
- P_CNT_W=4, 20 bad words in LOCKED with P_UNLOCK_CNT=32: err_cnt saturates at 15; i_rst mid-stream: all outputs return to reset values immediately.
